// File: rtl/seq_mp_adder_pkg.sv
// Shared types and constants for the multi-precision sequential adder.
// The FSM encoding and byte-index width helper live here so the top and bench agree.
package seq_mp_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-index counter width: never narrower than one bit, even for a single-byte build.
  function automatic int idx_width(input int nbytes);
    int w;
    w = $clog2(nbytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_mp_adder_if.sv
// Operand request / result response bundle for seq_mp_adder.
// The master side issues operands and consumes results; the adder is the slave.
interface seq_mp_adder_if #(
  parameter int NBYTES = 4
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  ci;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES:0]     s;
  logic                  busy;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, s, busy
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, s, busy
  );

endinterface

// File: rtl/seq_mp_adder_add8_slice.sv
// Single 8-bit carry-in adder slice; purely combinational.
// r[7:0] is the byte sum and r[8] the carry-out.
module add8_slice
  import seq_mp_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              cin,
  output logic [BYTE_W:0]   r
);

  assign r = {1'b0, x} + {1'b0, y} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/seq_mp_adder.sv
// Multi-precision adder that walks the operands LSB byte first through one 8-bit slice,
// registering the carry between bytes, and hands back the full NBYTES*8+1 bit sum.
module seq_mp_adder
  import seq_mp_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  seq_mp_adder_if.slave   bus
);

  localparam int IDXW = idx_width(NBYTES);
  localparam int W    = BYTE_W * NBYTES;

  localparam logic [1:0]      ST_IDLE  = IDLE;
  localparam logic [1:0]      ST_RUN   = RUN;
  localparam logic [1:0]      ST_DONE  = DONE;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic [W:0]      s_q,     s_d;

  logic [BYTE_W-1:0] slice_x;
  logic [BYTE_W-1:0] slice_y;
  logic [BYTE_W:0]   slice_r;

  assign slice_x = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
  assign slice_y = b_q[int'(idx_q)*BYTE_W +: BYTE_W];

  add8_slice u_slice (
    .x   (slice_x),
    .y   (slice_y),
    .cin (carry_q),
    .r   (slice_r)
  );

  always_comb begin
    // NOTE: every signal written here is defaulted to its held value first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.ci;
          idx_d   = '0;
          s_d     = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        s_d[int'(idx_q)*BYTE_W +: BYTE_W] = slice_r[BYTE_W-1:0];
        carry_d = slice_r[BYTE_W];
        // The last byte parks the index rather than wrapping it.
        if (idx_q == LAST_IDX) begin
          s_d[W]  = slice_r[BYTE_W];
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset too, so an aborted operation
  // leaves s at zero rather than exposing partial bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.s         = s_q;

endmodule

// File: tb/tb_seq_mp_adder.sv
// Randomised self-checking bench for seq_mp_adder: a 4-byte build and a 1-byte build,
// both compared against plain integer addition of the accepted operands.
module tb_seq_mp_adder;

  localparam int NB  = 4;
  localparam int NB1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_mp_adder_if #(.NBYTES(NB))  bus  ();
  seq_mp_adder_if #(.NBYTES(NB1)) bus1 ();

  seq_mp_adder #(.NBYTES(NB))  u_dut  (.clk(clk), .rst(rst), .bus(bus));
  seq_mp_adder #(.NBYTES(NB1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y, input logic c);
    return 33'(x) + 33'(y) + 33'(c);
  endfunction

  // One complete transaction on the 4-byte build with out_ready held high.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic c, input string name);
    logic [32:0] exp_s;
    int          n;
    exp_s = ref_sum(x, y, c);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
    end
    bus.a = x; bus.b = y; bus.ci = c; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 32'($urandom); bus.b = 32'($urandom); bus.ci = 1'($urandom_range(0, 1));
    n = 0;
    while (!bus.out_valid && n < 20) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s run flags: busy=%b in_ready=%b want 1/0", name, bus.busy, bus.in_ready);
      end
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n != NB) begin
      n_fail++; $display("FAIL %s latency: got %0d edges want %0d", name, n, NB);
    end
    n_checks++;
    if (bus.s !== exp_s) begin
      n_fail++; $display("FAIL %s sum: got %h want %h", name, bus.s, exp_s);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s return to idle: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                         name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.s !== '0) begin
      n_fail++; $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b s=%h want 1/0/0/0",
                         bus.in_ready, bus.out_valid, bus.busy, bus.s);
    end
    n_checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.s !== '0) begin
      n_fail++; $display("FAIL reset_state_nb1: in_ready=%b out_valid=%b busy=%b s=%h want 1/0/0/0",
                         bus1.in_ready, bus1.out_valid, bus1.busy, bus1.s);
    end
  endtask

  task automatic test_directed;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "carry_ripple");
    do_op(32'h1234_5678, 32'h1111_1111, 1'b1, "mixed_ci1");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "all_ones");
    do_op(32'h0000_0000, 32'h0000_0000, 1'b0, "all_zero");
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      do_op(32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_backpressure;
    logic [32:0] exp1, exp2;
    logic [31:0] x2, y2;
    int          n;
    exp1 = ref_sum(32'h89AB_CDEF, 32'h7654_3210, 1'b1);
    bus.out_ready = 1'b0;
    bus.a = 32'h89AB_CDEF; bus.b = 32'h7654_3210; bus.ci = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    x2 = 32'($urandom); y2 = 32'($urandom);
    exp2 = ref_sum(x2, y2, 1'b0);
    bus.a = x2; bus.b = y2; bus.ci = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n != NB) begin
      n_fail++; $display("FAIL bp_latency: got %0d edges want %0d", n, NB);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.s !== exp1) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b s=%h want 1/0/%h",
                           i, bus.out_valid, bus.in_ready, bus.s, exp1);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                         bus.in_ready, bus.out_valid, bus.busy);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_late_accept: busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
    end
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n != NB || bus.s !== exp2) begin
      n_fail++; $display("FAIL bp_second_op: latency=%0d s=%h want %0d/%h", n, bus.s, NB, exp2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h1357_9BDF; bus.ci = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.s !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_abort: out_valid=%b busy=%b s=%h in_ready=%b want 0/0/0/1",
                         bus.out_valid, bus.busy, bus.s, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NB + 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_pulse cycle %0d: out_valid=%b busy=%b want 0/0",
                           i, bus.out_valid, bus.busy);
      end
    end
    do_op(32'h0000_FF00, 32'h0000_0100, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp_q[$];
    int          acc_cyc[$];
    int          pulses, issued;
    logic [31:0] na, nb;
    logic        nci;
    logic        acc;
    logic [32:0] exp_s;
    pulses = 0; issued = 0;
    na = 32'($urandom); nb = 32'($urandom); nci = 1'($urandom_range(0, 1));
    bus.a = na; bus.b = nb; bus.ci = nci; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = bus.in_ready && bus.in_valid;
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(ref_sum(na, nb, nci));
        acc_cyc.push_back(cyc);
        issued++;
        if (issued == 3) begin
          bus.in_valid = 1'b0;
        end else begin
          na = 32'($urandom); nb = 32'($urandom); nci = 1'($urandom_range(0, 1));
          bus.a = na; bus.b = nb; bus.ci = nci;
        end
      end
      if (bus.out_valid) begin
        pulses++;
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (bus.s !== exp_s) begin
          n_fail++; $display("FAIL b2b_sum %0d: got %h want %h", pulses, bus.s, exp_s);
        end
      end
      if (issued == 3 && pulses >= 3 && !bus.busy) break;
    end
    n_checks++;
    if (issued != 3 || pulses != 3) begin
      n_fail++; $display("FAIL b2b_counts: accepts=%0d pulses=%0d want 3/3", issued, pulses);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != NB + 2) begin
        n_fail++; $display("FAIL b2b_spacing %0d: got %0d cycles want %0d",
                           i, acc_cyc[i] - acc_cyc[i-1], NB + 2);
      end
    end
  endtask

  task automatic test_nbytes1;
    logic [7:0] x, y;
    logic       c;
    logic [8:0] exp_s;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        x = 8'hFF; y = 8'h01; c = 1'b1;
      end else begin
        x = 8'($urandom); y = 8'($urandom); c = 1'($urandom_range(0, 1));
      end
      exp_s = 9'(x) + 9'(y) + 9'(c);
      bus1.a = x; bus1.b = y; bus1.ci = c; bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      n_checks++;
      if (bus1.busy !== 1'b1 || bus1.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL nb1_run %0d: busy=%b out_valid=%b want 1/0", i, bus1.busy, bus1.out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus1.out_valid !== 1'b1 || bus1.s !== exp_s) begin
        n_fail++; $display("FAIL nb1_result %0d: out_valid=%b s=%h want 1/%h", i, bus1.out_valid, bus1.s, exp_s);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL nb1_idle %0d: in_ready=%b out_valid=%b want 1/0", i, bus1.in_ready, bus1.out_valid);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_mid_op;
    test_back_to_back;
    test_nbytes1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_mp_adder.md
Name: seq_mp_adder

Overview:
- Multi-precision sequential adder. Accepts two NBYTES-wide operands and a carry-in over a valid/ready handshake.
- Adds them one byte per cycle, LSB first, on a single 8-bit carry-in adder slice. The carry is registered between bytes.
- Returns the full (8*NBYTES+1)-bit sum over a valid/ready handshake.
- Sits directly upstream of the 8-bit adder datapath: it sequences operand bytes and carries into the slice and collects what the slice produces.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 1..16.
- IDXW, max(1,$clog2(NBYTES)), byte-index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  8*NBYTES  operand A.
- b  input  8*NBYTES  operand B.
- ci  input  1  carry-in for bit 0.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- s  output  8*NBYTES+1  sum; the MSB is the final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, active-high, effective immediately at any state):
  - state=IDLE; idx=0; carry=0; a/b operand registers=0; s=0.
  - out_valid=0, busy=0. in_ready=1 once state=IDLE.
- Handshakes: a transfer occurs on a rising edge where valid&ready=1. Inputs are sampled only on accept. Later changes to a/b/ci have no effect on the operation in flight.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept: latch a, b; carry<=ci; idx<=0; s<=0; go RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the slice computes {c,sum8} = a[8*idx+:8] + b[8*idx+:8] + carry.
  - s[8*idx+:8]<=sum8; carry<=c; idx<=idx+1.
  - When idx==NBYTES-1: s[8*NBYTES]<=c and go DONE; idx does not wrap past NBYTES-1.
- DONE:
  - out_valid=1; s is held stable.
  - On out_ready=1: go IDLE and drop out_valid on that edge.
  - With out_ready=0: stay indefinitely; s, carry and in_ready=0 are unchanged.
- Latency:
  - Operands are accepted on edge E.
  - out_valid is high after edge E+NBYTES.
  - Minimum issue interval is NBYTES+2 cycles (accept, NBYTES RUN cycles, one DONE cycle). There is no accept in the same cycle as result handoff.
- Arithmetic: unsigned modulo-free. s equals the exact a+b+ci, NBYTES*8+1 bits, with no overflow loss.
- NBYTES=1: exactly one RUN cycle; IDXW=1; the idx compare is still against 0.
- in_valid is ignored outside IDLE. A new request is not queued.
- Reset during RUN or DONE aborts the operation. No out_valid pulse is produced for it, and s reads 0.
- s bits not yet written during RUN read 0. The consumer must qualify s with out_valid.

Decomposition:
- Package seq_mp_adder_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Constant BYTE_W=8.
  - Function for IDXW.
- Sub-module add8_slice: purely combinational.
  - Inputs x[7:0], y[7:0], cin.
  - Output r[8:0]: r[7:0] is the byte sum, r[8] the carry-out.
  - Instantiated once.
- All sequencing, operand byte muxing and result assembly live in the top module.

Test Plan (NBYTES=4):
- After reset: a=0xFFFFFFFF, b=0x00000001, ci=0, in_valid=1 accepted on edge E, out_ready=1 → out_valid high after edge E+4, s=0x1_00000000; carry propagates across all 4 byte steps.
- a=0x12345678, b=0x11111111, ci=1 → s=0x0_2345678A. a=0xFFFFFFFF, b=0xFFFFFFFF, ci=1 → s=0x1_FFFFFFFF.
- Backpressure: result in DONE, out_ready=0 for 10 cycles while in_valid=1 with new operands → s, out_valid=1 and in_ready=0 stable throughout. Raise out_ready → next cycle IDLE, in_ready=1, and the new operands are accepted only then.
- Reset mid-op: assert rst asynchronously after 2 RUN cycles (between edges) → immediately out_valid=0, busy=0, s=0. After deassert: in_ready=1, and the next op 0x0000FF00+0x00000100 ci=0 gives s=0x0_00010000.
- Back-to-back: 3 consecutive ops with in_valid held high and out_ready=1 → each accepted exactly NBYTES+2=6 cycles apart. Results match a reference model, and there are no spurious out_valid pulses.
- Corner: NBYTES=1 build, a=0xFF, b=0x01, ci=1 → s=0x101 with out_valid one cycle after the accept edge.
